// File: rtl/writeback_group_arbiter.sv
// writeback_group_arbiter: grants one done execution unit per cycle onto the registered WB group 1 port.
// Round-robin by default; define WB_ARB_OLDEST_FIRST_EN to grant the result closest to retirement first.
module writeback_group_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int ID_W      = 3,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_UNITS-1:0]        unit_done,
    input  logic [NUM_UNITS*ID_W-1:0]   unit_id,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
    output logic [NUM_UNITS-1:0]        unit_ack,
    input  logic [ID_W-1:0]             oldest_id,
    output logic                        wb_valid,
    output logic [ID_W-1:0]             wb_id,
    output logic [DATA_W-1:0]           wb_data
);

    localparam int               PTR_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_UNITS - 1);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              gnt_any;
    logic [PTR_W-1:0]  gnt_idx;
    logic [ID_W-1:0]   sel_id;
    logic [DATA_W-1:0] sel_data;

    logic              wb_valid_q;
    logic [ID_W-1:0]   wb_id_q;
    logic [DATA_W-1:0] wb_data_q;

    logic [ID_W-1:0]   id_arr   [NUM_UNITS];
    logic [DATA_W-1:0] data_arr [NUM_UNITS];

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
        assign id_arr[g]   = unit_id[g*ID_W +: ID_W];
        assign data_arr[g] = unit_data[g*DATA_W +: DATA_W];
    end

`ifdef WB_ARB_OLDEST_FIRST_EN
    // Age wraps modulo 2^ID_W, so the ID equal to oldest_id is age 0; strict < keeps ties on the lowest index.
    always_comb begin
        logic [ID_W-1:0] age;
        logic [ID_W-1:0] best_age;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        age      = '0;
        best_age = '1;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            age = id_arr[i] - oldest_id;
            if (unit_done[i] && (!gnt_any || (age < best_age))) begin
                gnt_any  = 1'b1;
                gnt_idx  = PTR_W'(i);
                best_age = age;
            end
        end
    end

    assign rr_ptr_d = '0;
`else
    // Candidate index is reduced by one subtraction, which keeps non-power-of-2 unit counts in range.
    localparam logic [PTR_W:0] NUM_EXT = (PTR_W + 1)'(NUM_UNITS);

    always_comb begin
        logic [PTR_W:0] cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned off = 0; off < NUM_UNITS; off++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(off);
            if (cand >= NUM_EXT) begin
                cand = cand - NUM_EXT;
            end
            if (!gnt_any && unit_done[cand[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any && !rst) begin
            rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    logic unused_oldest_id;
    assign unused_oldest_id = ^oldest_id;
`endif

    always_comb begin
        unit_ack = '0;
        if (gnt_any && !rst) begin
            unit_ack[gnt_idx] = 1'b1;
        end
    end

    assign sel_id   = id_arr[gnt_idx];
    assign sel_data = data_arr[gnt_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_id_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= |unit_ack;
            if (|unit_ack) begin
                wb_id_q   <= sel_id;
                wb_data_q <= sel_data;
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_id    = wb_id_q;
    assign wb_data  = wb_data_q;

    a_ack_onehot0 : assert property (@(posedge clk) $onehot0(unit_ack));
    a_ack_in_rst  : assert property (@(posedge clk) rst |-> (unit_ack == '0));
    a_ptr_range   : assert property (@(posedge clk) disable iff (rst) (rr_ptr_q <= LAST_IDX));

endmodule

// File: doc/writeback_group_arbiter.md
Name: writeback_group_arbiter

Overview:
Shares the single multicycle writeback port (WB group 1) among several ID-tagged execution units, such as load/store, multiply, divide and CSR. Each cycle it grants one pending unit, acknowledges it, and presents that unit's result in a registered wb packet to the ID-management and commit logic. Default policy is round-robin; an optional oldest-ID-first policy uses the current oldest retire ID.

Parameters:
NUM_UNITS, 4, number of requesting units (2..8)
ID_W, 3, instruction ID width (LOG2_MAX_IDS)
DATA_W, 32, writeback data width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
unit_done  input  NUM_UNITS  unit i holds a completed result
unit_id  input  NUM_UNITS*ID_W  ID of unit i result; slice i = [i*ID_W +: ID_W]
unit_data  input  NUM_UNITS*DATA_W  result data of unit i; slice i = [i*DATA_W +: DATA_W]
unit_ack  output  NUM_UNITS  one-hot grant; result consumed this cycle
oldest_id  input  ID_W  oldest un-retired ID (retire_ids_next[0]); ignored unless macro set
wb_valid  output  1  registered writeback valid
wb_id  output  ID_W  registered writeback ID
wb_data  output  DATA_W  registered writeback data

Behaviour:
- Unit handshake:
  - A unit asserts unit_done with stable unit_id/unit_data until the cycle unit_ack[i]=1.
  - In the cycle after the ack, it may present a new result (done may stay high) or drop done.
  - Done must not be withdrawn before ack.
- Grant logic is combinational from unit_done and state.
  - unit_ack is zero-hot when no done is asserted, else one-hot.
  - unit_ack is forced to 0 while rst=1.
- Output stage is one register and never stalls.
  - On posedge: wb_valid <= |unit_ack.
  - wb_id/wb_data <= granted unit's fields when a grant occurs, else hold previous value.
  - Latency is 1 cycle from ack to wb_valid.
  - Throughput is 1 result/cycle; back-to-back grants to the same unit are legal.
- Round-robin (default):
  - Pointer rr_ptr (log2 NUM_UNITS bits) gives the highest-priority index.
  - Search order: rr_ptr, rr_ptr+1, ... wrapping modulo NUM_UNITS.
  - On a grant to k, rr_ptr <= (k+1) mod NUM_UNITS. With no grant, rr_ptr holds.
  - Wrap from NUM_UNITS-1 goes to 0. For non-power-of-2 NUM_UNITS, the pointer never takes values >= NUM_UNITS.
- Reset: rr_ptr=0, wb_valid=0, wb_id=0, wb_data=0.
  - Reset mid-operation discards any pending grant; no ack is issued in the reset cycle.
  - wb_valid=0 in the cycle after rst.
  - Units are responsible for clearing their own done on rst.
- Simultaneous events: a request arriving in the same cycle as another unit's grant waits for a later arbitration. No request is lost; the requester just stays pending.
- Fairness: with all units continuously requesting, each unit is granted exactly once per NUM_UNITS cycles.

Optional Feature:
Macro WB_ARB_OLDEST_FIRST_EN.
- Defined:
  - Age_i = (unit_id_i - oldest_id) mod 2^ID_W, unsigned ID_W bits.
  - Grant the done unit with minimum age; ties go to the lowest index.
  - rr_ptr is held at 0.
  - Purpose: reduces retire stalls by writing back the instruction closest to retirement first.
- Undefined: round-robin as above; the oldest_id port is present but unused.

Test Plan:
1. Reset: hold rst 2 cycles with unit_done=4'b1111 -> unit_ack=0 throughout; cycle after release: wb_valid=0 and rr_ptr=0; first grant goes to unit0.
2. Single request: unit_done=4'b0100, unit_id[2]=5, unit_data[2]=0xA5A5_0001 -> unit_ack=4'b0100 same cycle; next cycle wb_valid=1, wb_id=5, wb_data=0xA5A5_0001; following cycle wb_valid=0 if no request.
3. Full contention: all four done continuously from rr_ptr=0 with ids 0..3 -> acks 0001,0010,0100,1000,0001; wb_id sequence 0,1,2,3 on consecutive cycles, wb_valid=1 continuously.
4. Wrap: grant unit1 (rr_ptr->2), then done=4'b1001 -> grant unit3, then unit0; rr_ptr ends at 1.
5. Oldest-first (macro on, ID_W=3): oldest_id=6, unit0 id=1 (age 3), unit1 id=7 (age 1), unit3 id=6 (age 0) -> order unit3, unit1, unit0.
6. Back-to-back same unit: unit2 alone, done held high, new id/data each cycle (ids 2,3,4) -> ack[2]=1 every cycle; wb_id 2,3,4 on consecutive cycles with no bubbles.
